rr_mux8way16: RTL and testbench
===============================

Name: rr_mux8way16

Overview:
- Registered 8-way, 16-bit round-robin multiplexer: the gathering counterpart of the 8-way 16-bit demultiplexer tree.
- Eight producer channels a..h each present a 16-bit word with valid/ready.
- The block grants one channel per transfer with a rotating priority pointer and places the word plus its 3-bit source index in a single output register.
- Sits where fanned-out 16-bit traffic is merged back onto one bus, e.g. RAM/peripheral return paths.

Parameters:
- WIDTH, 16, data width per channel and of out.
- N, 8, channel count; fixed at 8 (sel width 3). Not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- a, b, c, d, e, f, g, h  input  16 each  channel 0..7 data.
- in_valid  input  8  bit i = channel i has a word.
- in_ready  output  8  bit i = channel i's word is accepted this cycle; combinational, one-hot or zero.
- out  output  16  registered merged data.
- sel  output  3  registered source index of out (a=0 … h=7).
- out_valid  output  1  out/sel hold a word.
- out_ready  input  1  consumer accepts out this cycle.
- busy_cnt  output  16  registered count of completed output transfers; wraps.

Behaviour:
- Reset, rst_n=0 at a clk edge:
  - out=0, sel=0, out_valid=0, busy_cnt=0, pointer ptr=0.
  - in_ready=0 combinationally while rst_n=0.
- Load condition: load_ok = !out_valid | out_ready.
- Grant (combinational):
  - Scan i = ptr, ptr+1, … ptr+7, all mod 8.
  - The first i with in_valid[i]=1 is the grant.
  - in_ready[grant] = load_ok; all other in_ready bits = 0.
  - No grant when in_valid=0.
- On a clk edge with rst_n=1:
  - If load_ok and a grant exists:
    - out <= data[grant], sel <= grant, out_valid <= 1.
    - ptr <= (grant+1) mod 8; wraps from 7 to 0.
  - Else if out_valid & out_ready: out_valid <= 0. out and sel keep their last value.
  - Otherwise all registers hold.
  - busy_cnt increments by 1 (mod 2^16) on every edge where out_valid & out_ready.
- Throughput and latency:
  - Accept-to-out_valid latency is 1 cycle.
  - Sustains one word per cycle when out_ready is held at 1. A simultaneous drain and reload is allowed, with no bubble.
- Stall: while out_valid=1 and out_ready=0, in_ready=0 and out/sel stay stable.
- Producers may change data or deassert in_valid in any cycle their in_ready=0; no word is lost or duplicated.
- Fairness: a channel holding in_valid=1 is granted within 8 grants.
- ptr does not move without a grant.
- Reset mid-transfer: a pending output word is discarded (out_valid=0). No in_ready asserts in the reset cycle.

Decomposition:
- Shared package/header: WIDTH=16, N=8, SEL_W=3 constants.
- One natural sub-module, rr_arbiter8: takes in_valid[7:0], ptr[2:0] and outputs grant[2:0] plus found. It is purely combinational and uses a rotate, priority-encode, rotate-back structure.
- The top level holds the data mux, output register, pointer and counter.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with in_valid=8'hFF → in_ready=0, out_valid=0, out=0, sel=0, busy_cnt=0.
- Single channel: c=16'hBEEF, in_valid=8'h04, out_ready=1 → in_ready=8'h04 in that cycle; next cycle out=16'hBEEF, sel=2, out_valid=1; busy_cnt=1 one cycle later.
- Round-robin:
  - Stimulus: in_valid=8'hFF held, out_ready=1, channel i data = 16'h1000+i.
  - Expect sel sequence 0,1,…,7,0 on consecutive cycles with no bubble.
  - Expect busy_cnt=8 after 8 transfers.
- Backpressure:
  - Stimulus: out_valid=1 holding d (sel=3), out_ready=0 for 5 cycles, in_valid=8'h81.
  - Expect in_ready=0 and out/sel unchanged for all 5 cycles.
  - Then out_ready=1 → next grant is h (ptr=4) → sel=7.
- Pointer wrap and skip:
  - Stimulus: after a grant to g (ptr=7), in_valid=8'h03.
  - Expect the grant order a (sel=0) then b (sel=1), ptr ending at 2.
- Reset mid-operation and counter wrap:
  - Force busy_cnt to 16'hFFFF via 65535 transfers, then 1 more → busy_cnt=0.
  - Assert rst_n=0 while out_valid=1 → next cycle out_valid=0, ptr=0.

Source files
------------

// File: rtl/rr_mux8way16_pkg.sv
// Shared constants for the 8-way, 16-bit round-robin merge.
package rr_mux8way16_pkg;
  localparam int WIDTH = 16;
  localparam int N     = 8;
  localparam int SEL_W = 3;
endpackage

// File: rtl/rr_arbiter8.sv
// Combinational round-robin arbiter: rotate requests to start at ptr,
// priority-encode the lowest set bit, then rotate the index back.
module rr_arbiter8
  import rr_mux8way16_pkg::*;
(
  input  logic [N-1:0]     in_valid,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             found
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [SEL_W-1:0] off;

  always_comb begin
    dbl   = {in_valid, in_valid} >> ptr;
    rot   = dbl[N-1:0];
    off   = '0;
    found = 1'b0;
    // Descending scan so the lowest rotated index (closest to ptr) wins.
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        off   = SEL_W'(j);
        found = 1'b1;
      end
    end
    grant = ptr + off;
  end

endmodule

// File: rtl/rr_mux8way16.sv
// Registered 8:1 round-robin merge of 16-bit channels with source index
// and a wrapping count of completed output transfers.
module rr_mux8way16
  import rr_mux8way16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [WIDTH-1:0] out,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      busy_cnt
);

  // Handshake: a word moves on any rising edge where valid and ready are
  // both 1; a producer may change data or drop valid whenever its ready is 0.

  logic [WIDTH-1:0] data [N];
  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      busy_q, busy_d;
  logic [SEL_W-1:0] grant;
  logic             found;
  logic             load_ok;

  assign data[0] = a;
  assign data[1] = b;
  assign data[2] = c;
  assign data[3] = d;
  assign data[4] = e;
  assign data[5] = f;
  assign data[6] = g;
  assign data[7] = h;

  rr_arbiter8 u_arb (
    .in_valid (in_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .found    (found)
  );

  always_comb begin
    load_ok     = !out_valid_q || out_ready;
    in_ready    = '0;
    out_d       = out_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    if (rst_n && found && load_ok) begin
      in_ready[grant] = 1'b1;
    end
    if (found && load_ok) begin
      out_d       = data[grant];
      sel_d       = grant;
      out_valid_d = 1'b1;
      ptr_d       = grant + SEL_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (out_valid_q && out_ready) begin
      busy_d = busy_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      out_q       <= out_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out       = out_q;
  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign busy_cnt  = busy_q;

endmodule

// File: tb/tb_rr_mux8way16.sv
// Directed bench for rr_mux8way16: reset, single channel, rotation,
// backpressure, pointer wrap, counter wrap and reset mid-transfer.
module tb_rr_mux8way16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b, c, d, e, f, g, h;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [15:0] out;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] busy_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rr_mux8way16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .h         (h),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy_cnt  (busy_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  // Advance past the next rising edge so outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic set_data_ramp();
    a = 16'h1000; b = 16'h1001; c = 16'h1002; d = 16'h1003;
    e = 16'h1004; f = 16'h1005; g = 16'h1006; h = 16'h1007;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 8'hFF;
    out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0; e = '0; f = '0; g = '0; h = '0;

    // Reset held two cycles with every channel requesting.
    tick();
    settle();
    check("rst_in_ready", in_ready, 8'h00);
    tick();
    settle();
    check("rst_in_ready2", in_ready, 8'h00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, 16'h0000);
    check("rst_sel", sel, 3'd0);
    check("rst_busy", busy_cnt, 16'h0000);

    // Single channel c.
    rst_n     = 1'b1;
    c         = 16'hBEEF;
    in_valid  = 8'h04;
    out_ready = 1'b1;
    settle();
    check("single_in_ready", in_ready, 8'h04);
    tick();
    in_valid = 8'h00;
    check("single_out", out, 16'hBEEF);
    check("single_sel", sel, 3'd2);
    check("single_valid", out_valid, 1'b1);
    check("single_busy0", busy_cnt, 16'd0);
    tick();
    check("single_busy1", busy_cnt, 16'd1);
    check("single_drained", out_valid, 1'b0);

    // Fresh reset so rotation starts from pointer 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_data_ramp();
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("rr_sel%0d", k), sel, 32'(k % 8));
      check($sformatf("rr_out%0d", k), out, 32'(16'h1000 + (k % 8)));
      check($sformatf("rr_valid%0d", k), out_valid, 1'b1);
    end
    check("rr_busy8", busy_cnt, 16'd8);

    // Load d (pointer moves to 4), then stall five cycles.
    in_valid = 8'h08;
    tick();
    check("bp_sel_d", sel, 3'd3);
    out_ready = 1'b0;
    in_valid  = 8'h81;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("bp_in_ready%0d", k), in_ready, 8'h00);
      d = 16'hDEAD;
      tick();
      check($sformatf("bp_sel%0d", k), sel, 3'd3);
      check($sformatf("bp_out%0d", k), out, 16'h1003);
      check($sformatf("bp_valid%0d", k), out_valid, 1'b1);
    end
    d = 16'h1003;
    out_ready = 1'b1;
    settle();
    check("bp_release_ready", in_ready, 8'h80);
    tick();
    check("bp_sel_h", sel, 3'd7);
    check("bp_out_h", out, 16'h1007);
    check("bp_busy", busy_cnt, 16'd10);

    // Grant g (pointer to 7), then a and b wrap past 7.
    in_valid = 8'h40;
    tick();
    check("wrap_sel_g", sel, 3'd6);
    in_valid = 8'h03;
    settle();
    check("wrap_ready_a", in_ready, 8'h01);
    tick();
    check("wrap_sel_a", sel, 3'd0);
    settle();
    check("wrap_ready_b", in_ready, 8'h02);
    tick();
    check("wrap_sel_b", sel, 3'd1);
    in_valid = 8'hFF;
    settle();
    check("wrap_ptr2", in_ready, 8'h04);
    check("wrap_busy", busy_cnt, 16'd13);

    // Counter wrap: 65522 more transfers reach 16'hFFFF.
    for (int k = 0; k < 65522; k++) tick();
    check("cnt_ffff", busy_cnt, 16'hFFFF);
    check("cnt_sel", sel, 3'd3);
    tick();
    check("cnt_wrap", busy_cnt, 16'h0000);
    check("cnt_sel2", sel, 3'd4);

    // Reset while a word is pending.
    check("mid_valid_pre", out_valid, 1'b1);
    rst_n = 1'b0;
    settle();
    check("mid_in_ready", in_ready, 8'h00);
    tick();
    check("mid_valid", out_valid, 1'b0);
    check("mid_out", out, 16'h0000);
    check("mid_busy", busy_cnt, 16'h0000);
    rst_n = 1'b1;
    settle();
    check("mid_ptr0", in_ready, 8'h01);
    tick();
    check("mid_sel0", sel, 3'd0);
    check("mid_out0", out, 16'h1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
